// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-channel TDM link.
// Recovers frame alignment from sync and presents complete frames in parallel.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [1:0]       slot, slot_n;
    logic [WIDTH-1:0] sh0, sh1, sh2;
    logic [WIDTH-1:0] sh0_n, sh1_n, sh2_n;
    logic [WIDTH-1:0] oa_n, ob_n, oc_n, od_n;
    logic             fv_n, err_n;

    // Beat classification while locked.
    logic             at_slot0;
    logic             ok_sync;
    logic             early_sync;
    logic             miss_sync;
    logic             mid_beat;
    logic             last_beat;

    assign at_slot0   = (slot == 2'd0);
    assign ok_sync    = sync && at_slot0;
    assign early_sync = sync && !at_slot0;
    assign miss_sync  = !sync && at_slot0;
    assign mid_beat   = !sync && !at_slot0 && (slot != 2'd3);
    assign last_beat  = !sync && (slot == 2'd3);

    assign locked = (state == LOCKED);

    // State, slot, shadow and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_c       <= '0;
            out_d       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            sh0         <= sh0_n;
            sh1         <= sh1_n;
            sh2         <= sh2_n;
            out_a       <= oa_n;
            out_b       <= ob_n;
            out_c       <= oc_n;
            out_d       <= od_n;
            frame_valid <= fv_n;
            sync_err    <= err_n;
        end
    end

    // Next-state: hunt for sync, then steer each beat into its slot.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        sh0_n   = sh0;
        sh1_n   = sh1;
        sh2_n   = sh2;
        oa_n    = out_a;
        ob_n    = out_b;
        oc_n    = out_c;
        od_n    = out_d;
        fv_n    = 1'b0;
        err_n   = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        sh0_n   = din;
                        slot_n  = 2'd1;
                        state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    unique case (1'b1)
                        ok_sync: begin
                            sh0_n  = din;
                            slot_n = 2'd1;
                        end
                        early_sync: begin
                            // Partial frame dropped; this beat restarts it.
                            err_n  = 1'b1;
                            sh0_n  = din;
                            slot_n = 2'd1;
                        end
                        miss_sync: begin
                            err_n   = 1'b1;
                            slot_n  = 2'd0;
                            state_n = HUNT;
                        end
                        mid_beat: begin
                            if (slot == 2'd1) begin
                                sh1_n = din;
                            end else begin
                                sh2_n = din;
                            end
                            slot_n = slot + 2'd1;
                        end
                        last_beat: begin
                            oa_n   = sh0;
                            ob_n   = sh1;
                            oc_n   = sh2;
                            od_n   = din;
                            fv_n   = 1'b1;
                            slot_n = 2'd0;
                        end
                        default: begin
                            slot_n = slot;
                        end
                    endcase
                end
                default: begin
                    state_n = HUNT;
                    slot_n  = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed vector table plus full-rate frame sequence.
// Expected values are hand-computed per vector.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       sync;
    logic [3:0] out_a, out_b, out_c, out_d;
    logic       frame_valid, locked, sync_err;

    int vec_cnt = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic       dv;
        logic       sy;
        logic [3:0] din;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic       fv;
        logic       lk;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .sync(sync),
        .out_a(out_a),
        .out_b(out_b),
        .out_c(out_c),
        .out_d(out_d),
        .frame_valid(frame_valid),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic dv, input logic sy,
                       input logic [3:0] di, input logic [15:0] o,
                       input logic fv, input logic lk, input logic er);
        vec_t v;
        v.rst = r;
        v.dv  = dv;
        v.sy  = sy;
        v.din = di;
        v.a   = o[15:12];
        v.b   = o[11:8];
        v.c   = o[7:4];
        v.d   = o[3:0];
        v.fv  = fv;
        v.lk  = lk;
        v.er  = er;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [18:0] act,
                         input logic [18:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got abcd=%h fv/lk/er=%b, want abcd=%h fv/lk/er=%b",
                     nm, act[18:3], act[2:0], exp[18:3], exp[2:0]);
        end
    endtask

    task automatic drive(input logic r, input logic dv, input logic sy,
                         input logic [3:0] di);
        @(negedge clk);
        rst       = r;
        din_valid = dv;
        sync      = sy;
        din       = di;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fv_seen;
        int err_seen;
        logic [15:0] exp_o;

        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        sync = 1'b0;

        // reset
        add(1, 0, 0, 4'h0, 16'h0000, 0, 0, 0);
        // first frame 1,0,1,1
        add(0, 1, 1, 4'h1, 16'h0000, 0, 1, 0);
        add(0, 1, 0, 4'h0, 16'h0000, 0, 1, 0);
        add(0, 1, 0, 4'h1, 16'h0000, 0, 1, 0);
        add(0, 1, 0, 4'h1, 16'h1011, 1, 1, 0);
        // three full-rate frames
        add(0, 1, 1, 4'hA, 16'h1011, 0, 1, 0);
        add(0, 1, 0, 4'hB, 16'h1011, 0, 1, 0);
        add(0, 1, 0, 4'hC, 16'h1011, 0, 1, 0);
        add(0, 1, 0, 4'hD, 16'hABCD, 1, 1, 0);
        add(0, 1, 1, 4'h1, 16'hABCD, 0, 1, 0);
        add(0, 1, 0, 4'h2, 16'hABCD, 0, 1, 0);
        add(0, 1, 0, 4'h3, 16'hABCD, 0, 1, 0);
        add(0, 1, 0, 4'h4, 16'h1234, 1, 1, 0);
        add(0, 1, 1, 4'h9, 16'h1234, 0, 1, 0);
        add(0, 1, 0, 4'h8, 16'h1234, 0, 1, 0);
        add(0, 1, 0, 4'h7, 16'h1234, 0, 1, 0);
        add(0, 1, 0, 4'h6, 16'h9876, 1, 1, 0);
        // gap of two idle cycles between slot 1 and slot 2
        add(0, 1, 1, 4'hE, 16'h9876, 0, 1, 0);
        add(0, 1, 0, 4'hF, 16'h9876, 0, 1, 0);
        add(0, 0, 1, 4'h5, 16'h9876, 0, 1, 0);
        add(0, 0, 0, 4'h7, 16'h9876, 0, 1, 0);
        add(0, 1, 0, 4'h0, 16'h9876, 0, 1, 0);
        add(0, 1, 0, 4'h1, 16'hEF01, 1, 1, 0);
        // early sync on slot 2
        add(0, 1, 1, 4'h3, 16'hEF01, 0, 1, 0);
        add(0, 1, 0, 4'h4, 16'hEF01, 0, 1, 0);
        add(0, 1, 1, 4'h5, 16'hEF01, 0, 1, 1);
        add(0, 1, 0, 4'h6, 16'hEF01, 0, 1, 0);
        add(0, 1, 0, 4'h7, 16'hEF01, 0, 1, 0);
        add(0, 1, 0, 4'h8, 16'h5678, 1, 1, 0);
        // missing sync on slot 0, then recovery
        add(0, 1, 0, 4'h9, 16'h5678, 0, 0, 1);
        add(0, 1, 0, 4'hA, 16'h5678, 0, 0, 0);
        add(0, 1, 0, 4'hB, 16'h5678, 0, 0, 0);
        add(0, 1, 1, 4'hC, 16'h5678, 0, 1, 0);
        add(0, 1, 0, 4'hD, 16'h5678, 0, 1, 0);
        add(0, 1, 0, 4'hE, 16'h5678, 0, 1, 0);
        add(0, 1, 0, 4'hF, 16'hCDEF, 1, 1, 0);
        // reset after slot-1 beat
        add(0, 1, 1, 4'h1, 16'hCDEF, 0, 1, 0);
        add(0, 1, 0, 4'h2, 16'hCDEF, 0, 1, 0);
        add(1, 1, 0, 4'h3, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 4'h3, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 4'h4, 16'h0000, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].dv, tbl[i].sy, tbl[i].din);
            check($sformatf("vec%0d", i),
                  {out_a, out_b, out_c, out_d, frame_valid, locked, sync_err},
                  {tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
                   tbl[i].fv, tbl[i].lk, tbl[i].er});
        end

        // Full-rate run: frame_valid exactly on every 4th beat.
        drive(1, 0, 0, 4'h0);
        fv_seen  = 0;
        err_seen = 0;
        exp_o    = 16'h0000;
        for (int f = 0; f < 4; f++) begin
            for (int s = 0; s < 4; s++) begin
                drive(0, 1, (s == 0), 4'(f * 4 + s));
                if (frame_valid) fv_seen++;
                if (sync_err) err_seen++;
                if (s == 3) begin
                    exp_o = {4'(f * 4), 4'(f * 4 + 1),
                             4'(f * 4 + 2), 4'(f * 4 + 3)};
                end
                check($sformatf("run f%0d s%0d", f, s),
                      {out_a, out_b, out_c, out_d, frame_valid, locked, sync_err},
                      {exp_o, (s == 3), 1'b1, 1'b0});
            end
        end
        check("run fv count", {16'h0, 3'(fv_seen)}, {16'h0, 3'd4});
        check("run err count", {16'h0, 3'(err_seen)}, {16'h0, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division 1-to-4 demultiplexer: the receive end of a 4-channel TDM link.
- The transmitter is a 4:1 selector whose select lines step through channels a, b, c, d on successive beats.
- This block recovers the frame boundary from a sync marker, steers each beat into its channel, and presents all four channels in parallel once a frame is complete.
- It sits directly after the serial link, ahead of per-channel logic.

Parameters:
WIDTH, 1, bit width of each channel sample (din and each out_*).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  WIDTH  serial TDM sample for the current slot
din_valid  input  1  din/sync qualify this cycle; no advance when low
sync  input  1  high on the slot-0 (channel a) beat of every frame
out_a  output  WIDTH  channel a sample (slot 0) of last complete frame
out_b  output  WIDTH  channel b sample (slot 1)
out_c  output  WIDTH  channel c sample (slot 2)
out_d  output  WIDTH  channel d sample (slot 3)
frame_valid  output  1  one-cycle pulse: out_a..out_d just updated
locked  output  1  high while frame alignment held
sync_err  output  1  one-cycle pulse: sync protocol violation

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: out_a..out_d=0, frame_valid=0, locked=0, sync_err=0, slot counter=0, state=HUNT, shadow regs=0. Reset mid-frame discards the partial frame; outputs are 0 after the edge.
- Accepted beat = din_valid high at a rising edge. With din_valid low nothing changes, except that the frame_valid/sync_err pulses drop.
- 2-bit slot counter, slot 0..3, wraps 3->0. Slot-to-channel mapping: 0->a, 1->b, 2->c, 3->d.
- State HUNT:
  - Beats without sync are ignored.
  - Beat with sync: shadow[0]<=din, slot<=1, state<=LOCKED.
- State LOCKED (locked=1):
  - sync with slot==0: normal. shadow[0]<=din, slot<=1.
  - no sync with slot!=0: normal. Store din into slot, slot<=slot+1.
  - Slot-3 beat (no sync): out_a<=shadow[0], out_b<=shadow[1], out_c<=shadow[2], out_d<=din, frame_valid<=1, slot<=0, all in the same edge.
  - sync with slot!=0 (early sync): sync_err pulse; partial frame discarded; beat taken as new slot 0 (shadow[0]<=din, slot<=1); stay LOCKED.
  - no sync with slot==0 (missing sync): sync_err pulse; beat discarded; state<=HUNT, slot<=0, locked drops next cycle.
- Latency: out_* and frame_valid update on the edge that accepts the slot-3 beat, so they are visible in the following cycle. frame_valid is high exactly one cycle per complete frame.
- Outputs hold their last complete-frame values indefinitely. Partial frames never reach out_*.
- Back-to-back frames at full rate (din_valid always high): frame_valid is high 1 cycle in 4.
- Gaps (din_valid low) may fall anywhere inside a frame without affecting alignment.
- frame_valid and sync_err are never both high. sync_err only comes from a beat that cannot complete a frame.

Test Plan:
- Reset then 4 beats at WIDTH=1, sync on first, din=1,0,1,1 -> after 4th beat out_a..d=1,0,1,1, frame_valid one cycle, locked=1 from second cycle on.
- WIDTH=4, 3 consecutive frames A1..D1, A2..D2, A3..D3 with din_valid always high -> frame_valid every 4th cycle, outputs match each frame, no sync_err.
- Same frame with din_valid low for 2 cycles between slot 1 and slot 2 -> identical outputs, frame_valid delayed by 2 cycles.
- Locked, sync asserted on slot-2 beat -> sync_err pulse, previous out_* unchanged, next 3 beats plus that one form frame, frame_valid after 4 beats counted from the early sync.
- Locked, slot-0 beat without sync -> sync_err, locked=0; further beats ignored until sync, then normal frame recovered.
- Assert rst after slot-1 beat of a frame -> all outputs 0, locked=0; remaining beats without sync ignored.
